// File: rtl/panel_switch_conditioner_if.sv
// Switch-side bundle for panel_switch_conditioner: raw pins and repeat enables in,
// debounced levels and one-cycle pulses out. Vectors are MSB-first: element 0 is channel 0.
interface panel_switch_conditioner_if #(
   parameter int N_SW = 8
);
   logic [0:N_SW-1] raw_n;
   logic [0:N_SW-1] repeat_en;
   logic [0:N_SW-1] level;
   logic [0:N_SW-1] press;
   logic [0:N_SW-1] release_pulse;
   logic            trigger;
   logic            busy;

   modport slave (
      input  raw_n,
      input  repeat_en,
      output level,
      output press,
      output release_pulse,
      output trigger,
      output busy
   );

   modport master (
      output raw_n,
      output repeat_en,
      input  level,
      input  press,
      input  release_pulse,
      input  trigger,
      input  busy
   );
endinterface

// File: rtl/panel_switch_conditioner.sv
// Front-panel switch conditioner: synchroniser, per-channel debounce, and a lockout FSM
// that grants one owning switch at a time with optional auto-repeat while it is held.
module panel_switch_conditioner #(
   parameter int N_SW            = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_RATE     = 10000000
) (
   input logic                     clk,
   input logic                     reset,
   panel_switch_conditioner_if.slave sw
);

   localparam int OWN_W   = (N_SW > 1) ? $clog2(N_SW) : 1;
   // Repeat counter is sized from the repeat intervals so long hold times fit independently of CNT_W.
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);
   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RPT_W-1:0] DLY_LAST  = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RATE_LAST = RPT_W'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCKED = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   logic [0:N_SW-1]  sync_r [SYNC_STAGES];
   logic [0:N_SW-1]  s_s;
   logic [CNT_W-1:0] cnt_r [N_SW];
   logic [0:N_SW-1]  level_r;
   logic [0:N_SW-1]  rise_s;
   logic [0:N_SW-1]  fall_s;

   state_t           state_r, state_n;
   logic [OWN_W-1:0] owner_r, owner_n, first_s;
   logic [RPT_W-1:0] rpt_r, rpt_n;
   logic             phase_r, phase_n;
   logic             rpt_due_s;
   logic [0:N_SW-1]  press_r, press_n;
   logic [0:N_SW-1]  rel_r, rel_n;
   logic             trigger_r;
   logic             busy_r;

   // Synchroniser chain; idles at 1 (switch released).
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_r[k] <= '1;
      end else begin
         sync_r[0] <= sw.raw_n;
         for (int k = 1; k < SYNC_STAGES; k++) sync_r[k] <= sync_r[k-1];
      end
   end

   assign s_s = ~sync_r[SYNC_STAGES-1];

   // Level-change markers: asserted on the cycle the debounced level is about to flip.
   always_comb begin
      rise_s = '0;
      fall_s = '0;
      for (int i = 0; i < N_SW; i++) begin
         if ((s_s[i] != level_r[i]) && (cnt_r[i] == DB_LAST)) begin
            if (s_s[i]) rise_s[i] = 1'b1;
            else        fall_s[i] = 1'b1;
         end else begin
            rise_s[i] = 1'b0;
            fall_s[i] = 1'b0;
         end
      end
   end

   // Per-channel stability counters and debounced levels.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_SW; i++) cnt_r[i] <= '0;
         level_r <= '0;
      end else begin
         for (int i = 0; i < N_SW; i++) begin
            if (s_s[i] == level_r[i]) begin
               cnt_r[i] <= '0;
            end else if (cnt_r[i] == DB_LAST) begin
               level_r[i] <= s_s[i];
               cnt_r[i]   <= '0;
            end else begin
               cnt_r[i] <= cnt_r[i] + CNT_W'(1);
            end
         end
      end
   end

   // Lockout FSM next-state and pulse decode; the lowest-index rising channel wins.
   always_comb begin
      state_n = state_r;
      owner_n = owner_r;
      rpt_n   = rpt_r;
      phase_n = phase_r;
      press_n = '0;
      rel_n   = '0;
      first_s = '0;
      for (int i = N_SW - 1; i >= 0; i--) begin
         if (rise_s[i]) first_s = OWN_W'(i);
         else           first_s = first_s;
      end
      rpt_due_s = phase_r ? (rpt_r == RATE_LAST) : (rpt_r == DLY_LAST);
      case (state_r)
         IDLE: begin
            if (|rise_s) begin
               owner_n          = first_s;
               press_n[first_s] = 1'b1;
               state_n          = LOCKED;
               rpt_n            = '0;
               phase_n          = 1'b0;
            end else begin
               state_n = IDLE;
            end
         end
         LOCKED: begin
            if (fall_s[owner_r]) begin
               rel_n[owner_r] = 1'b1;
               state_n        = DRAIN;
               rpt_n          = '0;
               phase_n        = 1'b0;
            end else if (sw.repeat_en[owner_r]) begin
               if (rpt_due_s) begin
                  press_n[owner_r] = 1'b1;
                  rpt_n            = '0;
                  phase_n          = 1'b1;
               end else begin
                  rpt_n = rpt_r + RPT_W'(1);
               end
            end else begin
               rpt_n   = '0;
               phase_n = 1'b0;
            end
         end
         DRAIN: begin
            if (level_r == '0) state_n = IDLE;
            else               state_n = DRAIN;
         end
         default: begin
            state_n = IDLE;
            rpt_n   = '0;
            phase_n = 1'b0;
         end
      endcase
   end

   // Lockout FSM state and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         owner_r   <= '0;
         rpt_r     <= '0;
         phase_r   <= 1'b0;
         press_r   <= '0;
         rel_r     <= '0;
         trigger_r <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_n;
         owner_r   <= owner_n;
         rpt_r     <= rpt_n;
         phase_r   <= phase_n;
         press_r   <= press_n;
         rel_r     <= rel_n;
         trigger_r <= |press_n;
         busy_r    <= (state_n != IDLE);
      end
   end

   assign sw.level         = level_r;
   assign sw.press         = press_r;
   assign sw.release_pulse = rel_r;
   assign sw.trigger       = trigger_r;
   assign sw.busy          = busy_r;

endmodule

// File: tb/tb_panel_switch_conditioner.sv
// Bench for panel_switch_conditioner: directed switch sequences checked against a
// sample-window/age-arithmetic model every cycle, plus literal expectations at key points.
module tb_panel_switch_conditioner;

   localparam int N  = 4;
   localparam int DB = 4;
   localparam int DL = 10;
   localparam int RT = 3;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   panel_switch_conditioner_if #(.N_SW(N)) sw();

   panel_switch_conditioner #(
      .N_SW(N), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DB), .CNT_W(20),
      .REPEAT_DELAY(DL), .REPEAT_RATE(RT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .sw(sw)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Model state
   logic [0:3] rawq [$];
   logic [0:3] sq [$];
   logic [0:3] m_level = '0;
   logic [0:3] e_press = '0;
   logic [0:3] e_rel   = '0;
   logic       e_trig  = 1'b0;
   logic       e_busy  = 1'b0;
   int         mode    = 0;
   int         owner   = 0;
   int         base    = 0;
   int         cyc     = 0;
   bit         started = 1'b0;

   always @(posedge clk) begin
      logic [0:3] s, old_level, rise, fall;
      bit         all_diff;
      int         age;
      started = 1'b1;
      cyc++;
      e_press = '0;
      e_rel   = '0;
      if (reset) begin
         rawq.delete();
         sq.delete();
         m_level = '0;
         mode    = 0;
         owner   = 0;
         base    = 0;
      end else begin
         s = (rawq.size() >= 2) ? ~rawq[rawq.size()-2] : 4'b0000;
         rawq.push_back(sw.raw_n);
         if (rawq.size() > 4) void'(rawq.pop_front());
         sq.push_back(s);
         if (sq.size() > DB) void'(sq.pop_front());
         old_level = m_level;
         rise = '0;
         fall = '0;
         // A level flips once the last DB synchronised samples all disagree with it.
         for (int i = 0; i < N; i++) begin
            all_diff = (sq.size() == DB);
            foreach (sq[k]) if (sq[k][i] == old_level[i]) all_diff = 1'b0;
            if (all_diff) begin
               m_level[i] = ~old_level[i];
               if (m_level[i]) rise[i] = 1'b1;
               else            fall[i] = 1'b1;
            end
         end
         if (mode == 0) begin
            for (int i = 0; i < N; i++) begin
               if (rise[i] && mode == 0) begin
                  owner = i;
                  e_press[i] = 1'b1;
                  mode = 1;
                  base = cyc;
               end
            end
         end else if (mode == 1) begin
            if (fall[owner]) begin
               e_rel[owner] = 1'b1;
               mode = 2;
            end else if (!sw.repeat_en[owner]) begin
               base = cyc;
            end else begin
               age = cyc - base;
               if (age >= DL && ((age - DL) % RT) == 0) e_press[owner] = 1'b1;
            end
         end else begin
            if (old_level == 4'b0000) mode = 0;
         end
      end
      e_trig = |e_press;
      e_busy = (mode != 0);
   end

   always @(negedge clk) begin
      if (started) begin
         chk("level",   sw.level,         m_level);
         chk("press",   sw.press,         e_press);
         chk("release", sw.release_pulse, e_rel);
         chk("trigger", {3'b000, sw.trigger}, {3'b000, e_trig});
         chk("busy",    {3'b000, sw.busy},    {3'b000, e_busy});
      end
   end

   initial begin
      reset        = 1'b1;
      sw.raw_n     = 4'b1111;
      sw.repeat_en = 4'b0000;
      tick(3);
      chk("reset_level", sw.level, 4'b0000);
      chk("reset_press", sw.press, 4'b0000);
      chk("reset_busy",  {3'b000, sw.busy}, 4'b0000);
      reset = 1'b0;
      tick(2);

      // 1: three-cycle glitch on channel 1 is rejected
      sw.raw_n = 4'b1011;
      tick(3);
      sw.raw_n = 4'b1111;
      tick(10);
      chk("glitch_level", sw.level, 4'b0000);
      chk("glitch_busy",  {3'b000, sw.busy}, 4'b0000);

      // 2: held channel 1 accepted after 6 cycles, released 6 cycles after letting go
      sw.raw_n = 4'b1011;
      tick(5);
      chk("accept_early", sw.press, 4'b0000);
      tick(1);
      chk("accept_press", sw.press, 4'b0100);
      chk("accept_level", sw.level, 4'b0100);
      chk("accept_trig",  {3'b000, sw.trigger}, 4'b0001);
      chk("accept_busy",  {3'b000, sw.busy}, 4'b0001);
      tick(1);
      chk("press_1cycle", sw.press, 4'b0000);
      tick(5);
      sw.raw_n = 4'b1111;
      tick(5);
      chk("rel_early", sw.release_pulse, 4'b0000);
      tick(1);
      chk("rel_pulse", sw.release_pulse, 4'b0100);
      chk("rel_busy",  {3'b000, sw.busy}, 4'b0001);
      tick(1);
      chk("rel_idle",  {3'b000, sw.busy}, 4'b0000);
      tick(3);

      // 3: simultaneous 0 and 2 -> only 0; 2 never pressed
      sw.raw_n = 4'b0101;
      tick(6);
      chk("simul_press", sw.press, 4'b1000);
      chk("simul_level", sw.level, 4'b1010);
      tick(5);
      sw.raw_n = 4'b1101;
      tick(6);
      chk("simul_rel",   sw.release_pulse, 4'b1000);
      chk("simul_nopr",  sw.press, 4'b0000);
      tick(8);
      chk("drain_busy",  {3'b000, sw.busy}, 4'b0001);
      sw.raw_n = 4'b1111;
      tick(6);
      chk("drain_norel", sw.release_pulse, 4'b0000);
      chk("drain_level", sw.level, 4'b0000);
      tick(1);
      chk("drain_idle",  {3'b000, sw.busy}, 4'b0000);
      tick(3);

      // 4: auto-repeat on channel 3 at T, T+10, T+13, T+16
      sw.repeat_en = 4'b0001;
      sw.raw_n = 4'b1110;
      tick(6);
      chk("rpt_T",    sw.press, 4'b0001);
      tick(9);
      chk("rpt_T9",   sw.press, 4'b0000);
      tick(1);
      chk("rpt_T10",  sw.press, 4'b0001);
      tick(2);
      chk("rpt_T12",  sw.press, 4'b0000);
      tick(1);
      chk("rpt_T13",  sw.press, 4'b0001);
      tick(3);
      chk("rpt_T16",  sw.press, 4'b0001);
      sw.raw_n = 4'b1111;
      tick(6);
      chk("rpt_rel",  sw.release_pulse, 4'b0001);
      chk("rpt_nopr", sw.press, 4'b0000);
      tick(1);
      chk("rpt_idle", {3'b000, sw.busy}, 4'b0000);
      sw.repeat_en = 4'b0000;
      tick(3);

      // 5: reset while channel 2 is mid-debounce
      sw.raw_n = 4'b1101;
      tick(4);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      chk("rst_level", sw.level, 4'b0000);
      chk("rst_busy",  {3'b000, sw.busy}, 4'b0000);
      tick(5);
      chk("rst_early", sw.press, 4'b0000);
      tick(1);
      chk("rst_press", sw.press, 4'b0010);
      sw.raw_n = 4'b1111;
      tick(9);

      // 6: owner fall coincides with a due repeat -> release only
      sw.repeat_en = 4'b0001;
      sw.raw_n = 4'b1110;
      tick(6);
      chk("coll_accept", sw.press, 4'b0001);
      tick(4);
      sw.raw_n = 4'b1111;
      tick(6);
      chk("coll_rel",  sw.release_pulse, 4'b0001);
      chk("coll_nopr", sw.press, 4'b0000);
      chk("coll_trig", {3'b000, sw.trigger}, 4'b0000);
      tick(2);
      chk("coll_idle", {3'b000, sw.busy}, 4'b0000);
      sw.repeat_en = 4'b0000;
      tick(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
